// File: rtl/clk_div_sequencer.sv
// Runtime-programmable 50%-duty clock divider. Ratio changes are queued and
// applied only at output-period boundaries so clk_out never glitches.
module clk_div_sequencer #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy,
  output logic             tick,
  output logic             clk_out
);

  // Handshake: a ratio transfers on any posedge where cfg_valid & cfg_ready.
  // cfg_ready is high in IDLE and RUN, low in DRAIN while a ratio is pending.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] pend_div;
  logic             pend_vld;
  logic             hi_p;
  logic             hi_n;

  logic             accept;
  logic             legal;
  logic             last;
  logic [DIV_W:0]   half;
  logic [DIV_W:0]   cnt_inc;

  assign accept  = cfg_valid & cfg_ready;
  assign legal   = (cfg_div > DIV_W'(1));
  assign last    = (cnt == (cur_div - DIV_W'(1)));
  // Extra bit keeps ceil(d/2) from wrapping at the maximum ratio.
  assign half    = ({1'b0, cur_div} + (DIV_W+1)'(1)) >> 1;
  assign cnt_inc = {1'b0, cnt} + (DIV_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_div   <= DIV_W'(DEFAULT_DIV);
      pend_div  <= '0;
      pend_vld  <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      busy      <= 1'b0;
      tick      <= 1'b0;
      hi_p      <= 1'b0;
    end else begin
      tick    <= 1'b0;
      cfg_err <= accept & ~legal;
      case (state)
        IDLE: begin
          if (accept && legal) cur_div <= cfg_div;
          if (en) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            tick  <= 1'b1;
            hi_p  <= 1'b1;
          end
        end

        RUN: begin
          if (last) begin
            cnt <= '0;
            if (en) begin
              tick <= 1'b1;
              hi_p <= 1'b1;
              // A ratio accepted on the boundary waits for the following one.
              if (accept && legal) begin
                pend_div  <= cfg_div;
                pend_vld  <= 1'b1;
                cfg_ready <= 1'b0;
                state     <= DRAIN;
              end
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              hi_p  <= 1'b0;
              if (accept && legal) cur_div <= cfg_div;
            end
          end else begin
            cnt  <= cnt + DIV_W'(1);
            hi_p <= (cnt_inc < half);
            if (accept && legal) begin
              pend_div  <= cfg_div;
              pend_vld  <= 1'b1;
              cfg_ready <= 1'b0;
              state     <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (last) begin
            cnt       <= '0;
            pend_vld  <= 1'b0;
            cfg_ready <= 1'b1;
            if (pend_vld) cur_div <= pend_div;
            if (en) begin
              state <= RUN;
              tick  <= 1'b1;
              hi_p  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              hi_p  <= 1'b0;
            end
          end else begin
            cnt  <= cnt + DIV_W'(1);
            hi_p <= (cnt_inc < half);
          end
        end

        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          hi_p      <= 1'b0;
          cfg_ready <= 1'b1;
          pend_vld  <= 1'b0;
        end
      endcase
    end
  end

  // Half-cycle retime: ANDing with it trims odd-ratio high time by half a clk.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) hi_n <= 1'b0;
    else     hi_n <= hi_p;
  end

  assign clk_out = cur_div[0] ? (hi_p & hi_n) : hi_p;

endmodule

// File: tb/tb_clk_div_sequencer.sv
// Bench for clk_div_sequencer: period-level reference model feeds a scoreboard
// that a monitor checks by measuring every clk_out period in half-cycles.
module tb_clk_div_sequencer;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic             cfg_valid = 1'b0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic             cfg_ready;
  logic             cfg_err;
  logic [DIV_W-1:0] cur_div;
  logic             busy;
  logic             tick;
  logic             clk_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DIV_W-1:0] exp_q[$];
  int               err_q[$];

  // Reference model: period-granular view of the divider
  bit m_run;
  int m_left;
  int m_cur;
  bit m_pend_vld;
  int m_pend;

  // Monitor state
  bit               mon_open = 1'b0;
  logic [DIV_W-1:0] mon_exp;
  int               mon_cycles;
  int               mon_hi;
  int               mon_first;

  clk_div_sequencer #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .busy      (busy),
    .tick      (tick),
    .clk_out   (clk_out)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at cycle %0d", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    m_run      = 1'b0;
    m_left     = 0;
    m_cur      = DEFAULT_DIV;
    m_pend_vld = 1'b0;
    m_pend     = 0;
    exp_q.delete();
    err_q.delete();
  endtask

  task automatic model_start();
    m_run  = 1'b1;
    m_left = m_cur;
    exp_q.push_back(DIV_W'(m_cur));
  endtask

  // Advances the model across one posedge given the inputs presented to it.
  task automatic model_edge(input bit e, input bit v, input int d);
    bit acc;
    bit ok;
    acc = v && !m_pend_vld;
    ok  = (d >= 2);
    if (acc && !ok) err_q.push_back(cyc + 1);
    if (!m_run) begin
      if (acc && ok) m_cur = d;
      if (e) model_start();
    end else if (m_left > 1) begin
      m_left--;
      if (acc && ok) begin
        m_pend     = d;
        m_pend_vld = 1'b1;
      end
    end else begin
      if (m_pend_vld) begin
        m_cur      = m_pend;
        m_pend_vld = 1'b0;
      end
      if (e) begin
        if (acc && ok) begin
          m_pend     = d;
          m_pend_vld = 1'b1;
        end
        model_start();
      end else begin
        m_run = 1'b0;
        if (acc && ok) m_cur = d;
      end
    end
  endtask

  // Driver: called at posedge+1, compares registered state, drives, advances.
  task automatic step(input bit e, input bit v, input logic [DIV_W-1:0] d);
    check("cfg_ready", 32'(cfg_ready), 32'(!m_pend_vld));
    check("busy", 32'(busy), 32'(m_run));
    check("cur_div", 32'(cur_div), 32'(m_cur));
    en        = e;
    cfg_valid = v;
    cfg_div   = d;
    model_edge(e, v, int'(d));
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_run && n < 1000) begin
      step(1'b0, 1'b0, '0);
      n++;
    end
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
  endtask

  task automatic close_period();
    check("period_cycles", 32'(mon_cycles), 32'(mon_exp));
    check("high_halves", 32'(mon_hi), 32'(mon_exp));
    check("first_half", 32'(mon_first), mon_exp[0] ? 32'd0 : 32'd1);
    if (!busy) check("idle_clk_out", 32'(clk_out), 32'd0);
    mon_open = 1'b0;
  endtask

  // Monitor: measures periods from tick to tick (or to stop) in half-cycles
  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        mon_open = 1'b0;
      end else begin
        if (mon_open && (tick || !busy)) close_period();
        if (tick) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tick_unexpected got=tick want=no_tick at cycle %0d", cyc);
          end else begin
            mon_exp = exp_q.pop_front();
            check("tick_div", 32'(cur_div), 32'(mon_exp));
            mon_open   = 1'b1;
            mon_cycles = 0;
            mon_hi     = 0;
            mon_first  = int'(clk_out);
          end
        end
        if (mon_open) begin
          mon_cycles++;
          mon_hi += int'(clk_out);
        end
        if (cfg_err) begin
          if (err_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cfg_err_unexpected got=1 want=0 at cycle %0d", cyc);
          end else begin
            check("cfg_err_cycle", 32'(cyc), 32'(err_q.pop_front()));
          end
        end
      end
      @(negedge clk);
      #2;
      if (mon_open && !rst) mon_hi += int'(clk_out);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    bit               r_en;
    bit               r_v;
    int               k;
    logic [DIV_W-1:0] r_d;

    model_reset();
    #12;
    check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    check("rst_clk_out", 32'(clk_out), 32'd0);
    check("rst_cur_div", 32'(cur_div), 32'(DEFAULT_DIV));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Default ratio 5
    run(16);
    wait_idle();

    // Program 4 while idle, then run
    step(1'b0, 1'b1, 8'd4);
    run(13);
    wait_idle();

    // Running at 6, reprogram 3 mid-period
    step(1'b0, 1'b1, 8'd6);
    run(8);
    step(1'b1, 1'b1, 8'd3);
    run(14);

    // Illegal ratios while running
    step(1'b1, 1'b1, 8'd1);
    run(2);
    step(1'b1, 1'b1, 8'd0);
    run(7);
    wait_idle();

    // Ratio 7: drop en at cnt=1 together with a request for 2
    step(1'b0, 1'b1, 8'd7);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 8'd2);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    check("drop_cur_div", 32'(cur_div), 32'd2);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_clk_out", 32'(clk_out), 32'd0);
    wait_idle();

    // Same ratio re-requested, plus request on a boundary cycle
    step(1'b0, 1'b1, 8'd3);
    run(3);
    step(1'b1, 1'b1, 8'd3);
    run(2);
    step(1'b1, 1'b1, 8'd5);
    run(12);
    wait_idle();

    // Randomized traffic
    r_en = 1'b1;
    for (int i = 0; i < 700; i++) begin
      if ($urandom_range(0, 19) == 0) r_en = !r_en;
      r_v = ($urandom_range(0, 5) == 0);
      k   = int'($urandom_range(0, 9));
      if (k == 0)      r_d = '0;
      else if (k == 1) r_d = 8'd1;
      else if (k == 9) r_d = DIV_W'($urandom_range(20, 40));
      else             r_d = DIV_W'($urandom_range(2, 9));
      step(r_en, r_v, r_d);
    end
    wait_idle();

    // Ratio 255, reset in the middle of the high phase
    step(1'b0, 1'b1, 8'd255);
    run(60);
    #2;
    check("pre_rst_high", 32'(clk_out), 32'd1);
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    #1;
    check("rst_async_clk_out", 32'(clk_out), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_rst_cur_div", 32'(cur_div), 32'(DEFAULT_DIV));
    check("post_rst_cfg_ready", 32'(cfg_ready), 32'd1);
    run(12);
    wait_idle();

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("err_q_drained", 32'(err_q.size()), 32'd0);
    check("period_closed", 32'(mon_open), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
